// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the wait-state data memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int DMEM_DEPTH_DEF = 256;
  localparam int DMEM_LAT_DEF   = 2;
  localparam int DMEM_LAT_MAX   = 15;
  localparam int WORD_BYTES     = 4;

endpackage

// File: rtl/dmem_wait_counter.sv
// rtl/dmem_wait_counter.sv - 4-bit wait-state down-counter with load and enable
module dmem_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       last
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign last = (count == 4'd1);

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory that stalls the pipeline for LATENCY cycles per access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH_DEF,
  parameter int LATENCY = DMEM_LAT_DEF,
  parameter int ADDR_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        ack,
  output logic        err
);

  localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

  dmem_state_t state_q, state_d;

  logic [31:0]       mem [DEPTH];
  logic              rd_q, wr_q, mis_q, conf_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       data_q;

  logic              req, cnt_load, cnt_en, cnt_last, done_next;
  logic              op_rd, op_wr;
  logic [ADDR_W-1:0] op_idx;
  logic [31:0]       op_data;
  logic              unused_addr;

  assign req         = mem_read | mem_write;
  assign unused_addr = ^address[31:ADDR_W+2];

  dmem_wait_counter u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (LOAD_VAL),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    ack       = 1'b0;
    err       = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    done_next = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && rst) begin
          stall    = 1'b1;
          cnt_load = 1'b1;
          if (LATENCY == 1) begin
            state_d   = DONE;
            done_next = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d   = DONE;
          done_next = 1'b1;
        end
      end
      DONE: begin
        ack     = 1'b1;
        err     = mis_q | conf_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A single-cycle access completes on the accepting edge, before the capture registers are loaded.
  always_comb begin
    if (state_q == IDLE) begin
      op_rd   = mem_read;
      op_wr   = mem_write;
      op_idx  = address[ADDR_W+1:2];
      op_data = write_data;
    end else begin
      op_rd   = rd_q;
      op_wr   = wr_q;
      op_idx  = idx_q;
      op_data = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      mis_q     <= 1'b0;
      conf_q    <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      read_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        rd_q   <= mem_read;
        wr_q   <= mem_write;
        mis_q  <= (address[1:0] != 2'b00);
        conf_q <= mem_read & mem_write;
        idx_q  <= address[ADDR_W+1:2];
        data_q <= write_data;
      end
      // On a read/write conflict the write wins and read_data is left alone.
      if (done_next) begin
        if (op_wr)      mem[op_idx] <= op_data;
        else if (op_rd) read_data   <= mem[op_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder at LATENCY 2, 1 and 4
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr [3];
  logic        mw [3];
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic [31:0] rd [3];
  logic        st [3];
  logic        ak [3];
  logic        er [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(2), .ADDR_W(8)) u_lat2 (
    .clk(clk), .rst(rst), .mem_read(mr[0]), .mem_write(mw[0]), .address(ad[0]),
    .write_data(wd[0]), .read_data(rd[0]), .stall(st[0]), .ack(ak[0]), .err(er[0]));

  dmem_responder #(.DEPTH(256), .LATENCY(1), .ADDR_W(8)) u_lat1 (
    .clk(clk), .rst(rst), .mem_read(mr[1]), .mem_write(mw[1]), .address(ad[1]),
    .write_data(wd[1]), .read_data(rd[1]), .stall(st[1]), .ack(ak[1]), .err(er[1]));

  dmem_responder #(.DEPTH(256), .LATENCY(4), .ADDR_W(8)) u_lat4 (
    .clk(clk), .rst(rst), .mem_read(mr[2]), .mem_write(mw[2]), .address(ad[2]),
    .write_data(wd[2]), .read_data(rd[2]), .stall(st[2]), .ack(ak[2]), .err(er[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts just after a rising edge; returns just after the edge that ends DONE, request dropped.
  task automatic access(input int i, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int chg_at, input logic [31:0] chg_a,
                        output int ns, output logic [31:0] rdv, output logic ev,
                        output logic sd, output longint t);
    mr[i] = r; mw[i] = w; ad[i] = a; wd[i] = d;
    ns = 0; rdv = 'x; ev = 1'bx; sd = 1'bx; t = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ak[i]) begin
        rdv = rd[i]; ev = er[i]; sd = st[i]; t = $time;
        break;
      end
      if (st[i]) ns++;
      @(posedge clk); #1;
      if (ns == chg_at) ad[i] = chg_a;
    end
    @(posedge clk); #1;
    mr[i] = 1'b0; mw[i] = 1'b0;
  endtask

  int          ns, ns2;
  logic [31:0] rdv;
  logic        ev, sd;
  longint      t1, t2;

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mr[i] = 1'b0; mw[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    #12;
    chk("reset_stall", {31'd0, st[0]}, 32'd0);
    chk("reset_ack",   {31'd0, ak[0]}, 32'd0);
    chk("reset_err",   {31'd0, er[0]}, 32'd0);
    chk("reset_rdata", rd[0], 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // LATENCY=2 write then read
    access(0, 0, 1, 32'h20, 32'hDEADBEEF, -1, 0, ns, rdv, ev, sd, t1);
    chk("wr20_ack_seen", {31'd0, t1 != 0}, 32'd1);
    chk("wr20_stalls", ns, 2);
    chk("wr20_err", {31'd0, ev}, 32'd0);
    chk("wr20_done_stall", {31'd0, sd}, 32'd0);
    access(0, 1, 0, 32'h20, 32'h0, -1, 0, ns, rdv, ev, sd, t1);
    chk("rd20_stalls", ns, 2);
    chk("rd20_data", rdv, 32'hDEADBEEF);
    chk("rd20_err", {31'd0, ev}, 32'd0);
    @(negedge clk);
    chk("idle_stall", {31'd0, st[0]}, 32'd0);
    chk("idle_ack", {31'd0, ak[0]}, 32'd0);
    chk("idle_rdata_hold", rd[0], 32'hDEADBEEF);
    @(posedge clk); #1;

    // Reset in the middle of a pending write
    mw[0] = 1'b1; ad[0] = 32'h10; wd[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("midwait_stall", {31'd0, st[0]}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_stall_now", {31'd0, st[0]}, 32'd0);
    chk("rst_rdata_now", rd[0], 32'h0);
    mw[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(0, 1, 0, 32'h10, 32'h0, -1, 0, ns, rdv, ev, sd, t1);
    chk("rd10_after_rst", rdv, 32'h0);
    access(0, 1, 0, 32'h20, 32'h0, -1, 0, ns, rdv, ev, sd, t1);
    chk("rd20_after_rst", rdv, 32'h0);

    // Address wrap and misalignment
    access(0, 0, 1, 32'h400, 32'hA5A5A5A5, -1, 0, ns, rdv, ev, sd, t1);
    chk("wr400_err", {31'd0, ev}, 32'd0);
    access(0, 1, 0, 32'h000, 32'h0, -1, 0, ns, rdv, ev, sd, t1);
    chk("wrap_rd000", rdv, 32'hA5A5A5A5);
    access(0, 1, 0, 32'h402, 32'h0, -1, 0, ns, rdv, ev, sd, t1);
    chk("mis_rd402_data", rdv, 32'hA5A5A5A5);
    chk("mis_rd402_err", {31'd0, ev}, 32'd1);

    // Read/write conflict: write wins, read_data untouched
    access(0, 0, 1, 32'hC, 32'h1234, -1, 0, ns, rdv, ev, sd, t1);
    access(0, 1, 0, 32'hC, 32'h0, -1, 0, ns, rdv, ev, sd, t1);
    chk("pre_conf_rd", rdv, 32'h1234);
    access(0, 1, 1, 32'h8, 32'h55, -1, 0, ns, rdv, ev, sd, t1);
    chk("conf_ack_seen", {31'd0, t1 != 0}, 32'd1);
    chk("conf_err", {31'd0, ev}, 32'd1);
    chk("conf_rdata_kept", rdv, 32'h1234);
    access(0, 1, 0, 32'h8, 32'h0, -1, 0, ns, rdv, ev, sd, t1);
    chk("conf_word8", rdv, 32'h55);
    chk("conf_word8_err", {31'd0, ev}, 32'd0);

    // LATENCY=1 back-to-back store then load
    access(1, 0, 1, 32'h4, 32'h1, -1, 0, ns, rdv, ev, sd, t1);
    access(1, 1, 0, 32'h4, 32'h0, -1, 0, ns2, rdv, ev, sd, t2);
    chk("l1_sw_stalls", ns, 1);
    chk("l1_lw_stalls", ns2, 1);
    chk("l1_lw_data", rdv, 32'h1);
    chk("l1_spacing", 32'(t2 - t1), 32'd20);

    // LATENCY=4: address change during WAIT is ignored
    access(2, 0, 1, 32'h30, 32'h77, -1, 0, ns, rdv, ev, sd, t1);
    chk("l4_wr30_stalls", ns, 4);
    access(2, 0, 1, 32'h34, 32'h99, -1, 0, ns, rdv, ev, sd, t1);
    access(2, 1, 0, 32'h30, 32'h0, 1, 32'h34, ns, rdv, ev, sd, t1);
    chk("l4_chg_stalls", ns, 4);
    chk("l4_chg_data", rdv, 32'h77);
    chk("l4_chg_err", {31'd0, ev}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
